// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit owning the HI/LO registers.
// Ports: clk, reset (sync, active-high); start, md_op, src_a, src_b
// (E-stage md op and operands); hilo_sel; busy, hi, lo, md_out.
// md_op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
module ex_muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_CYC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_we;

  logic is_mul;
  logic is_div;
  logic is_sgn;
  logic is_mthi;
  logic is_mtlo;

  assign is_mul  = (md_op == 3'd0) || (md_op == 3'd1);
  assign is_div  = (md_op == 3'd2) || (md_op == 3'd3);
  assign is_sgn  = ~md_op[0];
  assign is_mthi = (md_op == 3'd4);
  assign is_mtlo = (md_op == 3'd5);

  // Sign-extending to 64 bits makes one unsigned multiply
  // yield the correct low 64 bits for both signed and unsigned.
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  assign mul_a = {{32{is_sgn & src_a[31]}}, src_a};
  assign mul_b = {{32{is_sgn & src_b[31]}}, src_b};
  assign prod  = mul_a * mul_b;

  // Signed divide on magnitudes: quotient truncates toward zero,
  // remainder takes the dividend's sign.
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign a_neg    = is_sgn & src_a[31];
  assign b_neg    = is_sgn & src_b[31];
  assign div_zero = (src_b == 32'd0);
  assign a_mag    = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag    = b_neg ? (~src_b + 32'd1) : src_b;
  assign den      = div_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / den;
  assign r_mag    = a_mag % den;
  assign quo      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem      = a_neg ? (~r_mag + 32'd1) : r_mag;

  // Result is computed at accept and parked until the counter expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else if (busy) begin
      cnt  <= cnt - ONE;
      busy <= (cnt != ONE);
      if (cnt == ONE && pend_we) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (start) begin
      unique case (1'b1)
        is_mul: begin
          cnt     <= MUL_N;
          busy    <= 1'b1;
          pend_hi <= prod[63:32];
          pend_lo <= prod[31:0];
          pend_we <= 1'b1;
        end
        is_div: begin
          cnt     <= DIV_N;
          busy    <= 1'b1;
          pend_hi <= rem;
          pend_lo <= quo;
          pend_we <= ~div_zero;
        end
        is_mthi: hi <= src_a;
        is_mtlo: lo <= src_a;
        default: ;
      endcase
    end
  end

  assign md_out = hilo_sel ? hi : lo;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded E-stage operands (forwarded RD1_E/RD2_E values) and the md operation.
- Owns the architectural HI/LO registers and reports busy so the hazard unit can stall dependent md instructions in D.
- Serves MFHI/MFLO reads to the EX result mux and MTHI/MTLO writes.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is an md op, sampled on rising edge
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no-op
- src_a  input  32  forwarded rs value (E stage)
- src_b  input  32  forwarded rt value (E stage)
- hilo_sel  input  1  1 selects HI on md_out, 0 selects LO
- busy  output  1  operation in progress
- hi  output  32  HI register
- lo  output  32  LO register
- md_out  output  32  hilo_sel ? hi : lo, combinational

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset state: HI=0, LO=0, busy=0, cycle counter=0, operand/pending-result registers=0, so md_out=0.
- Reset overrides start in the same edge.
- Reset mid-operation aborts the operation: HI/LO are cleared and the pending result is discarded.
- busy is registered and equals (counter != 0).
- Accept rule: start is honoured only on an edge where busy=0.
  - start with busy=1 is ignored and has no side effects; the hazard unit guarantees this does not occur.
- MULT/MULTU/DIV/DIVU accepted at edge T:
  - src_a, src_b and md_op are captured internally; later changes on the inputs have no effect.
  - counter is loaded with N (MUL_CYCLES or DIV_CYCLES).
  - busy=1 during cycles T+1 .. T+N.
  - At edge T+N, HI/LO take the result and the counter returns to 0.
  - The new HI/LO values and busy=0 are visible from cycle T+N+1.
  - HI/LO keep their old values throughout the busy window.
- A new start may be accepted on the first edge with busy=0, i.e. back-to-back operations with no gap cycle.
- MTHI/MTLO accepted at edge T:
  - HI (resp. LO) <= src_a at edge T.
  - No busy cycles.
  - The other register is unchanged.
- md_op 6-7 with start=1: no state change.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = product[63:32], LO = product[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (src_b=0, DIV or DIVU): the full DIV_CYCLES busy window is still taken, and HI/LO are left unchanged at completion.
- Implementation freedom: the result may be computed at accept time and held in a pending register, or computed iteratively. Observable timing must be exactly as stated above.
- md_out is a purely combinational mux of the current HI/LO. A read in the same cycle as the completing edge returns the old value; the hazard unit stalls MFHI/MFLO while (start | busy).

Test Plan:
- Reset, then MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy=1 for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> busy for 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU 7/2 -> LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU x/0 -> busy 10 cycles, HI/LO unchanged.
- Mid-operation interference:
  - During a DIV, change src_a/src_b every cycle and pulse start with MTHI -> result matches the captured operands; the MTHI is ignored.
  - Assert reset at busy cycle 4 -> next cycle busy=0, HI=LO=0, no late write.
- MTHI src_a=0x12345678, then MTLO src_a=0x9ABCDEF0 on consecutive edges -> HI=0x12345678, LO=0x9ABCDEF0, busy never set.
  - md_out follows hilo_sel combinationally.
  - A MULT started on the edge busy falls after a DIV is accepted with zero gap.
